// File: rtl/rv_muldiv_unit_if.sv
// rv_muldiv_unit_if -- request/response bundle for the RV32M multiply/divide unit.
//   start, abort     : request strobe and cancel (master -> unit)
//   funct3           : M-extension opcode (master -> unit)
//   src1, src2       : rs1/rs2 operands (master -> unit)
//   ready, busy      : unit status (unit -> master)
//   done             : one-cycle completion pulse (unit -> master)
//   result           : registered result (unit -> master)
interface rv_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             abort;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, abort, funct3, src1, src2,
    input  ready, busy, done, result
  );

  modport slave (
    input  start, abort, funct3, src1, src2,
    output ready, busy, done, result
  );
endinterface

// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit -- iterative RV M-extension multiply/divide unit.
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// cycle on operand magnitudes; sign is applied when the result is written.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : rv_muldiv_unit_if slave (start/abort/funct3/src1/src2 in,
//           ready/busy/done/result out)
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; ready=1
// S_CALC | iterating (counter WIDTH..0) or one-cycle bypass for div special cases
// S_DONE | result just written; done=1 for exactly one cycle
module rv_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic             clock,
  input logic             reset,
  rv_muldiv_unit_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod;      // mul: {acc, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
  logic [2:0]         op;
  logic               neg_main;  // negate product / quotient
  logic               neg_rem;   // negate remainder (dividend sign)
  logic               byp;       // special-case divide; prod[WIDTH-1:0] already holds the answer
  logic [WIDTH-1:0]   result_q;

  // ---------------- acceptance-time decode ----------------
  logic             s1_signed_in, s2_signed_in;
  logic             a_neg_in, b_neg_in;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;
  logic             div_zero_in, ovf_in, byp_in;
  logic [WIDTH-1:0] byp_val_in;

  always_comb begin
    s1_signed_in = 1'b0;
    s2_signed_in = 1'b0;
    case (bus.funct3)
      3'b001, 3'b100, 3'b110: begin
        s1_signed_in = 1'b1;
        s2_signed_in = 1'b1;
      end
      3'b010:  s1_signed_in = 1'b1;
      default: ;
    endcase
  end

  assign a_neg_in    = s1_signed_in & bus.src1[WIDTH-1];
  assign b_neg_in    = s2_signed_in & bus.src2[WIDTH-1];
  assign a_mag_in    = a_neg_in ? (~bus.src1 + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.src1;
  assign b_mag_in    = b_neg_in ? (~bus.src2 + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.src2;
  assign div_zero_in = (bus.src2 == {WIDTH{1'b0}});
  assign ovf_in      = ((bus.funct3 == 3'b100) || (bus.funct3 == 3'b110))
                     && (bus.src1 == {1'b1, {(WIDTH-1){1'b0}}})
                     && (bus.src2 == {WIDTH{1'b1}});
  assign byp_in      = bus.funct3[2] & (div_zero_in | ovf_in);

  // funct3[1] distinguishes REM/REMU from DIV/DIVU
  always_comb begin
    byp_val_in = bus.src1;
    if (div_zero_in)
      byp_val_in = bus.funct3[1] ? bus.src1 : {WIDTH{1'b1}};
    else
      byp_val_in = bus.funct3[1] ? {WIDTH{1'b0}} : bus.src1;
  end

  // ---------------- iteration step ----------------
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] step_next;

  assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign div_shift = prod[2*WIDTH-1:WIDTH-1];
  assign div_ge    = (div_shift >= {1'b0, opnd});
  // Only used when div_ge, so the truncated difference is exact.
  assign div_diff  = div_shift[WIDTH-1:0] - opnd;
  assign step_next = op[2] ? (div_ge ? {div_diff, prod[WIDTH-2:0], 1'b1}
                                     : {prod[2*WIDTH-2:0], 1'b0})
                           : {mul_sum, prod[WIDTH-1:1]};

  // ---------------- completion sign fix-up ----------------
  logic [2*WIDTH-1:0] full_prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   final_val;

  assign full_prod = neg_main ? (~prod + {{(2*WIDTH-1){1'b0}}, 1'b1}) : prod;
  assign quo       = neg_main ? (~prod[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}) : prod[WIDTH-1:0];
  assign rem       = neg_rem  ? (~prod[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1})
                              : prod[2*WIDTH-1:WIDTH];

  always_comb begin
    final_val = full_prod[WIDTH-1:0];
    if (byp)
      final_val = prod[WIDTH-1:0];
    else
      case (op)
        3'b000:                 final_val = full_prod[WIDTH-1:0];
        3'b001, 3'b010, 3'b011: final_val = full_prod[2*WIDTH-1:WIDTH];
        3'b100, 3'b101:         final_val = quo;
        default:                final_val = rem;
      endcase
  end

  // ---------------- state machine ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      prod     <= '0;
      opnd     <= '0;
      op       <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      byp      <= 1'b0;
      result_q <= '0;
    end else if (bus.abort) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state    <= S_CALC;
            cnt      <= CNT_W'(WIDTH);
            op       <= bus.funct3;
            neg_main <= a_neg_in ^ b_neg_in;
            neg_rem  <= a_neg_in;
            byp      <= byp_in;
            if (byp_in) begin
              prod <= {{WIDTH{1'b0}}, byp_val_in};
              opnd <= b_mag_in;
            end else if (bus.funct3[2]) begin
              prod <= {{WIDTH{1'b0}}, a_mag_in};
              opnd <= b_mag_in;
            end else begin
              prod <= {{WIDTH{1'b0}}, b_mag_in};
              opnd <= a_mag_in;
            end
          end
        end
        S_CALC: begin
          if (byp || (cnt == '0)) begin
            state    <= S_DONE;
            cnt      <= '0;
            result_q <= final_val;
          end else begin
            prod <= step_next;
            cnt  <= cnt - CNT_W'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready  = (state == S_IDLE);
  assign bus.busy   = (state == S_CALC) || (state == S_DONE);
  assign bus.done   = (state == S_DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// tb_rv_muldiv_unit -- directed self-checking bench for rv_muldiv_unit (WIDTH=32).
module tb_rv_muldiv_unit;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  rv_muldiv_unit_if #(.WIDTH(32)) bus ();

  rv_muldiv_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called away from a clock edge; the next rising edge accepts the request.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input string tag);
    int lat;
    lat = 999;
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.src1   = a;
    bus.src2   = b;
    @(posedge clock); #1;
    bus.start  = 1'b0;
    bus.src1   = $urandom;
    bus.src2   = $urandom;
    bus.funct3 = 3'($urandom_range(0, 7));
    check(32'(bus.ready), 32'd0, {tag, "_accept"});
    for (int k = 1; k <= 60; k++) begin
      if (k == 5 && exp_lat > 10) bus.start = 1'b1;
      if (k == 7) bus.start = 1'b0;
      @(posedge clock); #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    bus.start = 1'b0;
    check(32'(lat), 32'(exp_lat), {tag, "_latency"});
    check(bus.result, exp, {tag, "_result"});
    @(posedge clock); #1;
    check(32'(bus.done), 32'd0, {tag, "_done_pulse"});
    check(32'(bus.ready), 32'd1, {tag, "_ready_after"});
  endtask

  initial begin
    int nd;
    checks     = 0;
    failures   = 0;
    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.funct3 = 3'b000;
    bus.src1   = '0;
    bus.src2   = '0;
    #1;
    check(32'(bus.ready),  32'd1, "rst_ready");
    check(32'(bus.busy),   32'd0, "rst_busy");
    check(32'(bus.done),   32'd0, "rst_done");
    check(bus.result,      32'd0, "rst_result");
    #1 reset = 1'b1;

    // first op accepted on the first rising edge with reset high
    run_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh");
    run_op(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33, "mulh_neg");
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
    run_op(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, "div");
    run_op(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, "rem");
    run_op(3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_negdivisor");
    run_op(3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33, "rem_negdivisor");
    run_op(3'b101, 32'd100,       32'd7,         32'd14,        33, "divu");
    run_op(3'b111, 32'd100,       32'd7,         32'd2,         33, "remu");
    run_op(3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 33, "divu_max");

    run_op(3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, "div_by0");
    run_op(3'b111, 32'd5,         32'd0,         32'd5,         1, "remu_by0");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "rem_ovf");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_prior");

    // abort mid-MUL with stray start pulses during CALC
    bus.start  = 1'b1;
    bus.funct3 = 3'b000;
    bus.src1   = 32'd3;
    bus.src2   = 32'd5;
    @(posedge clock); #1;
    bus.start = 1'b0;
    nd = 0;
    for (int k = 1; k <= 9; k++) begin
      if (k == 2) bus.start = 1'b1;
      if (k == 4) bus.start = 1'b0;
      @(posedge clock); #1;
      if (bus.done) nd++;
    end
    check(32'(bus.busy), 32'd1, "abort_busy_before");
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check(32'(bus.ready), 32'd1,          "abort_ready");
    check(32'(bus.busy),  32'd0,          "abort_busy");
    check(32'(bus.done),  32'd0,          "abort_done");
    check(bus.result,     32'hFFFF_FFFE, "abort_result_kept");
    repeat (40) begin
      @(posedge clock); #1;
      if (bus.done) nd++;
    end
    check(32'(nd), 32'd0, "abort_no_done");
    run_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_after_abort");

    // asynchronous reset mid-DIV
    bus.start  = 1'b1;
    bus.funct3 = 3'b101;
    bus.src1   = 32'd100;
    bus.src2   = 32'd7;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check(32'(bus.ready), 32'd1, "arst_ready");
    check(32'(bus.busy),  32'd0, "arst_busy");
    check(32'(bus.done),  32'd0, "arst_done");
    check(bus.result,     32'd0, "arst_result");
    #2 reset = 1'b1;
    nd = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (bus.done) nd++;
    end
    check(32'(nd), 32'd0, "arst_no_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_muldiv_unit.md
RV_MULDIV_UNIT -- requirements
Module: rv_muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (even, >= 8).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1, iteration-counter width.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request; accepted only when ready=1.
REQ-006 SHALL have port abort  input  1  cancels any operation in progress.
REQ-007 SHALL have port funct3  input  3  RV M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have port src1  input  WIDTH  rs1 operand (multiplicand/dividend).
REQ-009 SHALL have port src2  input  WIDTH  rs2 operand (multiplier/divisor).
REQ-010 SHALL have port ready  output  1  high only in IDLE.
REQ-011 SHALL have port busy  output  1  high in CALC or DONE.
REQ-012 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-013 SHALL have port result  output  WIDTH  registered result.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE.
REQ-015 IDLE: start=1 and abort=0 at an edge SHALL latch funct3/src1/src2, load counter=WIDTH, go to CALC; start ignored in CALC/DONE.
REQ-016 CALC SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle, decrementing counter; counter reaching 0 -> DONE.
REQ-017 Normal latency SHALL be: done high during cycle beginning WIDTH+1 edges after the acceptance edge.
REQ-018 DONE SHALL last exactly one cycle, assert done=1, then return to IDLE.
REQ-019 result SHALL update only on the CALC->DONE edge and hold until the next completion.
REQ-020 Signed ops SHALL operate on magnitudes and apply sign at completion: MULH signed x signed, MULHSU signed src1 x unsigned src2, MULHU unsigned; MULH* return bits [2*WIDTH-1:WIDTH] of the full product; MUL returns bits [WIDTH-1:0].
REQ-021 DIV/REM SHALL truncate toward zero; remainder sign SHALL equal dividend sign.
REQ-022 Divisor=0 SHALL bypass iteration: go directly to DONE on the next edge; DIV/DIVU result all-ones, REM/REMU result = src1.
REQ-023 Signed overflow (src1 = most-negative, src2 = -1, DIV/REM) SHALL bypass iteration like REQ-022: DIV result = src1, REM result = 0.
REQ-024 Bypass latency SHALL be: done high during the cycle following the acceptance edge.
REQ-025 abort=1 at an edge SHALL force IDLE from any state, suppress done, leave result unchanged; abort has priority over start.
REQ-026 Operand inputs SHALL be don't-care after acceptance (internal copies only).
REQ-027 ready, busy, done SHALL be registered-state decodes with no combinational path from start.

Reset
REQ-028 reset low SHALL asynchronously force IDLE, counter=0, result=0, done=0, busy=0, ready=1.
REQ-029 reset asserted mid-CALC SHALL discard the operation; no done after release.
REQ-030 first start SHALL be accepted at the first rising edge with reset high.

Verification (WIDTH=32)
REQ-031 MUL src1=0x0000_0007, src2=0xFFFF_FFFD -> done exactly 33 cycles after accept, result=0xFFFF_FFEB.
REQ-032 MULH 0x8000_0000 x 0x8000_0000 -> 0x4000_0000; MULHSU 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFF; MULHU same operands -> 0xFFFF_FFFE.
REQ-033 DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-034 DIV 5/0 -> 0xFFFF_FFFF, REMU 5/0 -> 5, DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000, REM same -> 0; each done 1 cycle after accept.
REQ-035 start MUL, abort at cycle 10, start pulses during CALC -> no done, ready=1 next cycle, result keeps prior value; new MUL accepted next completes normally.
REQ-036 reset low mid-DIV -> ready=1, result=0 immediately (no clock edge), no done afterwards.
